// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb: direct-mapped write-back write-allocate L1 data cache, 4-word lines.
// Define DCACHE_PERF_CNT_EN to add hit_cnt/miss_cnt performance counters.
module dcache_direct_wb #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = 28 - IDX_W;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t state;
    logic [127:0] data [NUM_BLOCKS];
    logic [TAG_W-1:0] tags [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid, dirty;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0] off;
    logic req, hit, idle, refill;
    assign idx = proc_addr[IDX_W+1:2];
    assign tag = proc_addr[29:IDX_W+2];
    assign off = proc_addr[1:0];
    assign req = proc_read | proc_write;
    assign hit = valid[idx] && tags[idx] == tag;
    assign idle = state == IDLE;
    assign refill = state == ALLOCATE && mem_ready;
    assign proc_stall = !idle || (req && !hit);
    assign proc_rdata = (idle && req && hit) ? data[idx][{off, 5'd0} +: 32] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE) begin
            if (req && hit && proc_write)
                dirty[idx] <= 1'b1;
            else if (req && !hit && valid[idx] && dirty[idx]) begin
                state     <= WRITEBACK;
                mem_write <= 1'b1;
                mem_addr  <= {tags[idx], idx};
                mem_wdata <= data[idx];
            end else if (req && !hit) begin
                state    <= ALLOCATE;
                mem_read <= 1'b1;
                mem_addr <= proc_addr[29:2];
            end
        end else if (state == WRITEBACK) begin
            if (mem_ready) begin
                state     <= ALLOCATE;
                mem_write <= 1'b0;
                mem_read  <= 1'b1;
                mem_addr  <= proc_addr[29:2];
            end
        end else if (state == ALLOCATE) begin
            if (mem_ready) begin
                state      <= IDLE;
                mem_read   <= 1'b0;
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end else
            state <= IDLE;
    end
    // Line storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (refill) begin
            data[idx] <= mem_rdata;
            tags[idx] <= tag;
        end else if (idle && req && hit && proc_write)
            data[idx][{off, 5'd0} +: 32] <= proc_wdata;
    end
`ifdef DCACHE_PERF_CNT_EN
    logic refilled;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refilled <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            refilled <= refill;
            if (idle && req && hit && !refilled)
                hit_cnt <= hit_cnt + 32'd1;
            if (idle && req && !hit)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_direct_wb.sv
// tb_dcache_direct_wb: directed bench with a line-level cache/memory model and a per-cycle compare process.
module tb_dcache_direct_wb;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         proc_read = 1'b0, proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    dcache_direct_wb #(.NUM_BLOCKS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_stall(proc_stall), .proc_rdata(proc_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    logic chk = 1'b0;
    logic exp_stall, exp_mr, exp_mw, chk_addr, chk_wdata, chk_rdata;
    logic [27:0]  exp_addr;
    logic [127:0] exp_wdata;
    logic [31:0]  exp_rdata;
    logic [127:0] seen_wb = '0;
    logic [27:0]  seen_ra = '0;

    // Model: what the cache holds, and what main memory holds, per line.
    logic         m_valid [8];
    logic         m_dirty [8];
    logic [24:0]  m_tag [8];
    logic [127:0] m_line [8];
    logic [127:0] mem_m [logic [27:0]];

    function automatic logic [127:0] mem_line(input logic [27:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {{2'b10, a, 2'd3}, {2'b10, a, 2'd2}, {2'b10, a, 2'd1}, {2'b10, a, 2'd0}};
    endfunction

    task automatic cmp(input string n, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("proc_stall", 128'(proc_stall), 128'(exp_stall));
            cmp("mem_read", 128'(mem_read), 128'(exp_mr));
            cmp("mem_write", 128'(mem_write), 128'(exp_mw));
            cmp("mem_rd_wr_exclusive", 128'(mem_read & mem_write), 128'(0));
            if (chk_addr) cmp("mem_addr", 128'(mem_addr), 128'(exp_addr));
            if (chk_wdata) cmp("mem_wdata", mem_wdata, exp_wdata);
            if (chk_rdata) cmp("proc_rdata", 128'(proc_rdata), 128'(exp_rdata));
        end
        if (mem_write) seen_wb = mem_wdata;
        if (mem_read) seen_ra = mem_addr;
    end

    task automatic set_exp(input logic s, input logic mr, input logic mw, input logic ca, input logic [27:0] a,
                           input logic cw, input logic [127:0] w, input logic cr, input logic [31:0] r);
        exp_stall = s; exp_mr = mr; exp_mw = mw;
        chk_addr = ca; exp_addr = a;
        chk_wdata = cw; exp_wdata = w;
        chk_rdata = cr; exp_rdata = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d, input int lat);
        logic [2:0] ix;
        logic [24:0] t;
        logic [27:0] la, victim;
        logic [1:0] o;
        ix = a[4:2]; t = a[29:5]; la = a[29:2]; o = a[1:0];
        proc_read = r; proc_write = w; proc_addr = a; proc_wdata = d;
        if (!(m_valid[ix] && m_tag[ix] == t)) begin
            set_exp(1, 0, 0, 0, '0, 0, '0, 0, '0);
            step();
            if (m_valid[ix] && m_dirty[ix]) begin
                victim = {m_tag[ix], ix};
                for (int k = 1; k <= lat; k++) begin
                    mem_ready = (k == lat);
                    set_exp(1, 0, 1, 1, victim, 1, m_line[ix], 0, '0);
                    step();
                end
                mem_ready = 1'b0;
                mem_m[victim] = m_line[ix];
            end
            for (int k = 1; k <= lat; k++) begin
                mem_ready = (k == lat);
                mem_rdata = (k == lat) ? mem_line(la) : '0;
                set_exp(1, 1, 0, 1, la, 0, '0, 0, '0);
                step();
            end
            mem_ready = 1'b0;
            mem_rdata = '0;
            m_line[ix] = mem_line(la);
            m_tag[ix] = t;
            m_valid[ix] = 1'b1;
            m_dirty[ix] = 1'b0;
        end
        set_exp(0, 0, 0, 0, '0, 0, '0, !w, m_line[ix][{o, 5'd0} +: 32]);
        step();
        if (w) begin
            m_line[ix][{o, 5'd0} +: 32] = d;
            m_dirty[ix] = 1'b1;
        end
    endtask

    task automatic idle_cycle(input logic rdy);
        proc_read = 1'b0; proc_write = 1'b0; mem_ready = rdy;
        set_exp(0, 0, 0, 0, '0, 0, '0, 1, '0);
        step();
        mem_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
        end
        mem_m[28'h4] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
        #2;
        cmp("rst proc_stall", 128'(proc_stall), 128'(0));
        cmp("rst mem_read", 128'(mem_read), 128'(0));
        cmp("rst mem_write", 128'(mem_write), 128'(0));
        cmp("rst mem_addr", 128'(mem_addr), 128'(0));
        cmp("rst mem_wdata", mem_wdata, 128'(0));
        cmp("rst proc_rdata", 128'(proc_rdata), 128'(0));
        #10 rst_n = 1'b1;
        step();
        chk = 1'b1;
        idle_cycle(1'b0);
        access(1, 0, 30'h10, 32'h0, 3);
        cmp("cold miss refill addr", 128'(seen_ra), 128'(28'h4));
        cmp("cold miss rdata", 128'(proc_rdata), 128'(32'h1111));
        access(1, 0, 30'h12, 32'h0, 1);
        cmp("read hit rdata", 128'(proc_rdata), 128'(32'h3333));
        access(0, 1, 30'h11, 32'hDEADBEEF, 1);
        access(1, 0, 30'h31, 32'h0, 2);
        cmp("writeback line", seen_wb, {32'h4444, 32'h3333, 32'hDEADBEEF, 32'h1111});
        cmp("conflict refill addr", 128'(seen_ra), 128'(28'hC));
        access(1, 0, 30'h11, 32'h0, 1);
        cmp("clean evict rdata", 128'(proc_rdata), 128'(32'hDEADBEEF));
        access(0, 1, 30'h08, 32'h12345678, 2);
        access(1, 0, 30'h08, 32'h0, 1);
        cmp("write miss rdata", 128'(proc_rdata), 128'(32'h12345678));
        access(1, 1, 30'h0A, 32'h0000CAFE, 1);
        access(1, 0, 30'h0A, 32'h0, 1);
        cmp("rd+wr as write", 128'(proc_rdata), 128'(32'h0000CAFE));
        idle_cycle(1'b1);
        access(1, 0, 30'h2A, 32'h0, 1);
        access(1, 0, 30'h09, 32'h0, 3);
        idle_cycle(1'b0);
        // Abort a refill with reset; the line must miss again afterwards.
        proc_read = 1'b1; proc_addr = 30'h40;
        set_exp(1, 0, 0, 0, '0, 0, '0, 0, '0);
        step();
        cmp("pre-abort mem_read", 128'(mem_read), 128'(1));
        chk = 1'b0;
        rst_n = 1'b0;
        #1;
        cmp("abort mem_read", 128'(mem_read), 128'(0));
        cmp("abort mem_write", 128'(mem_write), 128'(0));
        cmp("abort stall on invalid", 128'(proc_stall), 128'(1));
        proc_read = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        step();
        chk = 1'b1;
        access(1, 0, 30'h40, 32'h0, 2);
        access(1, 0, 30'h10, 32'h0, 1);
        cmp("post-reset refetch rdata", 128'(proc_rdata), 128'(32'h1111));
        idle_cycle(1'b0);
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
